bwt_sort_ctrl: RTL and testbench

Sequencer wrapped around the 8-byte merge-sort datapath (merge_sort_top) in the BWT pipeline. It:
- accepts a byte stream with a valid/ready handshake,
- assembles blocks of N bytes and pads short blocks,
- pulses the sorter's start and waits out its latency,
- captures the sorted block and streams it out with valid/ready/last.

It is the only block that drives the sorter's start and data_in.

---
 rtl/bwt_sort_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bwt_sort_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_sort_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bwt_sort_ctrl : block sequencer around the N-byte merge-sort datapath.
// Optional macro SORT_DONE_EN adds sort_done handshake and sticky err.
// Rev 1.0
// ----------------------------------------------------------------------------
module bwt_sort_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned SORT_LAT = 20,
  parameter logic [7:0]  PAD_CHAR = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    sort_start,
  output logic [8*N-1:0]          sort_data_in,
  input  logic [8*N-1:0]          sort_data_out,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [$clog2(N+1)-1:0]  blk_len
`ifdef SORT_DONE_EN
  ,
  input  logic                    sort_done,
  output logic                    err
`endif
);

  localparam int unsigned IDX_W = $clog2(N+1);
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned CNT_W = $clog2(SORT_LAT+1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_PAD   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;
  logic [IDX_W-1:0]   blk_len_q, blk_len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         blk_buf_q [N];
  logic [7:0]         blk_buf_d [N];
  logic [7:0]         obuf_q [N];
  logic [7:0]         obuf_d [N];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
`ifdef SORT_DONE_EN
  logic               err_q, err_d;
`endif

  assign wr_ptr  = idx_q[AW-1:0];
  assign rd_ptr  = ridx_q[AW-1:0];
  assign blk_len = blk_len_q;
  assign busy    = !((state_q == S_LOAD) && (idx_q == '0));
`ifdef SORT_DONE_EN
  assign err     = err_q;
`endif

  always_comb begin
    sort_data_in = '0;
    for (int i = 0; i < int'(N); i++) begin
      sort_data_in[8*i +: 8] = blk_buf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      ridx_q    <= '0;
      blk_len_q <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < int'(N); i++) begin
        blk_buf_q[i] <= '0;
        obuf_q[i]    <= '0;
      end
`ifdef SORT_DONE_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ridx_q    <= ridx_d;
      blk_len_q <= blk_len_d;
      cnt_q     <= cnt_d;
      blk_buf_q <= blk_buf_d;
      obuf_q    <= obuf_d;
`ifdef SORT_DONE_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ridx_d     = ridx_q;
    blk_len_d  = blk_len_q;
    cnt_d      = cnt_q;
    blk_buf_d  = blk_buf_q;
    obuf_d     = obuf_q;
`ifdef SORT_DONE_EN
    err_d      = err_q;
`endif
    in_ready   = 1'b0;
    sort_start = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;

    case (state_q)
      S_LOAD: begin
        // Held low during reset so nothing upstream sees a phantom accept.
        in_ready = rst;
        if (in_valid && rst) begin
          blk_buf_d[wr_ptr] = in_data;
          idx_d             = idx_q + 1'b1;
          if (in_last || (idx_q == IDX_W'(N-1))) begin
            blk_len_d = idx_q + 1'b1;
            state_d   = ((idx_q + 1'b1) < IDX_W'(N)) ? S_PAD : S_START;
          end
        end
      end
      S_PAD: begin
        blk_buf_d[wr_ptr] = PAD_CHAR;
        idx_d             = idx_q + 1'b1;
        if (idx_q == IDX_W'(N-1)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        sort_start = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
`ifdef SORT_DONE_EN
        if (sort_done) begin
          for (int i = 0; i < int'(N); i++) obuf_d[i] = sort_data_out[8*i +: 8];
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_W'(SORT_LAT-1)) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end
`else
        if (cnt_q == CNT_W'(SORT_LAT-1)) begin
          for (int i = 0; i < int'(N); i++) obuf_d[i] = sort_data_out[8*i +: 8];
          state_d = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = obuf_q[rd_ptr];
        out_last  = (ridx_q == IDX_W'(N-1));
        if (out_ready) begin
          ridx_d = ridx_q + 1'b1;
          if (ridx_q == IDX_W'(N-1)) begin
            ridx_d  = '0;
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bwt_sort_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bwt_sort_ctrl : randomized self-checking bench with a behavioural sorter.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bwt_sort_ctrl;
  localparam int N        = 8;
  localparam int SORT_LAT = 20;
  localparam logic [7:0] PAD = 8'h00;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     in_data = '0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           sort_start;
  logic [8*N-1:0] sort_data_in;
  logic [8*N-1:0] sort_data_out = '0;
  logic           out_valid;
  logic [7:0]     out_data;
  logic           out_last;
  logic           out_ready = 1'b0;
  logic           busy;
  logic [3:0]     blk_len;
`ifdef SORT_DONE_EN
  logic           sort_done = 1'b0;
  logic           err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int exp_starts = 0;
  bit b2b = 1'b0;

  always #5 clk = ~clk;

  bwt_sort_ctrl #(.N(N), .SORT_LAT(SORT_LAT), .PAD_CHAR(PAD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .sort_start(sort_start), .sort_data_in(sort_data_in), .sort_data_out(sort_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .blk_len(blk_len)
`ifdef SORT_DONE_EN
    , .sort_done(sort_done), .err(err)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ascending byte sort of a packed block (byte i at [8i+7:8i]).
  function automatic logic [8*N-1:0] sort_pack(input logic [8*N-1:0] v);
    logic [7:0] b [N];
    logic [7:0] tmp;
    logic [8*N-1:0] r;
    for (int i = 0; i < N; i++) b[i] = v[8*i +: 8];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1-i; j++)
        if (b[j] > b[j+1]) begin tmp = b[j]; b[j] = b[j+1]; b[j+1] = tmp; end
    r = '0;
    for (int i = 0; i < N; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [8*N-1:0] str2blk(input string s);
    logic [8*N-1:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < N; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Behavioural sorter: result appears a random few cycles after start.
  logic [8*N-1:0] srt_res = '0;
  int             srt_dly = 0;
  bit             srt_pend = 1'b0;
  always @(posedge clk) begin
    if (sort_start) begin
      n_start       <= n_start + 1;
      srt_res       <= sort_pack(sort_data_in);
      srt_dly       <= int'($urandom_range(2, 10));
      srt_pend      <= 1'b1;
      sort_data_out <= {$urandom, $urandom};
`ifdef SORT_DONE_EN
      sort_done     <= 1'b0;
`endif
    end else if (srt_pend) begin
      if (srt_dly == 0) begin
        sort_data_out <= srt_res;
        srt_pend      <= 1'b0;
`ifdef SORT_DONE_EN
        sort_done     <= 1'b1;
`endif
      end else begin
        srt_dly <= srt_dly - 1;
      end
    end else begin
`ifdef SORT_DONE_EN
      sort_done <= 1'b0;
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [8*N-1:0] data, input int len, input bit use_last,
                            input bit hold, input logic [7:0] nxt);
    int t;
    for (int k = 0; k < len; k++) begin
      in_valid = 1'b1;
      in_data  = data[8*k +: 8];
      in_last  = use_last && (k == len-1);
      t = 0;
      while (!in_ready && t < 300) begin step(); t++; end
      if (t >= 300) begin check_val("in_ready_timeout", 64'd0, 64'd1); return; end
      if (k == 0 && b2b) check_val("b2b_accept_delay", 64'(t), 64'd0);
      step();
    end
    b2b      = 1'b0;
    in_valid = hold;
    in_data  = nxt;
    in_last  = 1'b0;
  endtask

  task automatic run_block(input logic [8*N-1:0] data, input int len, input bit use_last,
                           input int mode, input bit hold, input logic [7:0] nxt);
    logic [8*N-1:0] exp_in, exp_out;
    logic [7:0] pd;
    logic pl, r;
    bit stalled;
    int t, k;
    exp_in = {N{PAD}};
    for (int i = 0; i < len; i++) exp_in[8*i +: 8] = data[8*i +: 8];
    exp_out = sort_pack(exp_in);
    send_block(data, len, use_last, hold, nxt);
    exp_starts++;
    t = 0;
    while (!sort_start && t < 50) begin
      check_val("in_ready_pad", 64'(in_ready), 64'd0);
      step(); t++;
    end
    check_val("pad_cycles", 64'(t), 64'(N-len));
    check_val("start_data", sort_data_in, exp_in);
    check_val("busy_start", 64'(busy), 64'd1);
    step();
    check_val("start_width", 64'(sort_start), 64'd0);
    t = 1;
    while (!out_valid && t < 100) begin step(); t++; end
    check_val("out_latency", 64'(t), 64'(SORT_LAT+1));
    check_val("blk_len", 64'(blk_len), 64'(len));
    k = 0; t = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
    while (k < N && t < 400) begin
      if (!out_valid) begin check_val("valid_drop", 64'd0, 64'd1); break; end
      if (stalled) check_val("stall_hold", {out_last, out_data}, {pl, pd});
      check_val("in_ready_drain", 64'(in_ready), 64'd0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (t % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (r) begin
        check_val("out_data", 64'(out_data), 64'(exp_out[8*k +: 8]));
        check_val("out_last", 64'(out_last), 64'(k == N-1));
        k++;
      end
      stalled = !r; pd = out_data; pl = out_last;
      step(); t++;
    end
    out_ready = 1'b0;
    check_val("in_ready_after", 64'(in_ready), 64'd1);
    check_val("busy_after", 64'(busy), 64'd0);
    check_val("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*N-1:0] d;
    int len, bad;
    #2;
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_out", {out_valid, out_last, out_data}, 64'd0);
    check_val("rst_start", 64'(sort_start), 64'd0);
    check_val("rst_blk_len", 64'(blk_len), 64'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check_val("rel_in_ready", 64'(in_ready), 64'd1);
    step();

    // Directed blocks
    run_block(str2blk("cadbabab"), 8, 1'b1, 0, 1'b0, 8'h00);
    check_val("t1_sorted", sort_pack(str2blk("cadbabab")), str2blk("aaabbbcd"));
    run_block(str2blk("twoab"), 5, 1'b1, 0, 1'b0, 8'h00);
    run_block(str2blk("babacdaf"), 8, 1'b1, 1, 1'b0, 8'h00);
    run_block(str2blk("z"), 1, 1'b1, 2, 1'b0, 8'h00);

    // Reset during WAIT aborts the block
    send_block(str2blk("cadbabab"), 8, 1'b1, 1'b0, 8'h00);
    exp_starts++;
    for (int t = 0; t < 20 && !sort_start; t++) step();
    for (int t = 0; t < 5; t++) step();
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_out", {out_valid, out_last, out_data}, 64'd0);
    check_val("mid_rst_ready", 64'(in_ready), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_blk_len", 64'(blk_len), 64'd0);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (out_valid || sort_start || !in_ready) bad++;
    end
    check_val("post_rst_quiet", 64'(bad), 64'd0);
    run_block(str2blk("dcba"), 4, 1'b1, 0, 1'b0, 8'h00);

    // Back-to-back with in_valid held high
    run_block(str2blk("hgfedcba"), 8, 1'b0, 2, 1'b1, 8'h71);
    b2b = 1'b1;
    run_block(str2blk("qrsab"), 5, 1'b1, 0, 1'b0, 8'h00);

    // Randomized blocks
    for (int b = 0; b < 8; b++) begin
      len = int'($urandom_range(1, N));
      d = '0;
      for (int i = 0; i < N; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
      run_block(d, len, (len < N) ? 1'b1 : 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'b0, 8'h00);
    end

    check_val("start_count", 64'(n_start), 64'(exp_starts));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
